// File: rtl/stoch_to_bin_pkg.sv
// Shared definitions for the stochastic-to-binary decoder:
// FSM state encoding and bipolar offset/clamp helpers.
package stoch_to_bin_pkg;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ACCUM = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   function automatic int bip_offset(input int w);
      return 1 << (w - 1);
   endfunction

   function automatic int bip_max(input int w);
      return (1 << (w - 1)) - 1;
   endfunction

   function automatic int bip_min(input int w);
      return -(1 << (w - 1));
   endfunction

endpackage

// File: rtl/stoch_to_bin_if.sv
// Control, sample and result handshake bundle of stoch_to_bin.
interface stoch_to_bin_if #(
   parameter int WIDTH = 8
);
   logic             START;
   logic             EN;
   logic             BIT_IN;
   logic             OUT_ACK;
   logic [WIDTH-1:0] VALUE;
   logic             OUT_VALID;
   logic             BUSY;
   logic             OVERRUN;

   modport master (
      output START, EN, BIT_IN, OUT_ACK,
      input  VALUE, OUT_VALID, BUSY, OVERRUN
   );

   modport slave (
      input  START, EN, BIT_IN, OUT_ACK,
      output VALUE, OUT_VALID, BUSY, OVERRUN
   );
endinterface

// File: rtl/stoch_ones_counter.sv
// EN-qualified ones/sample counters for one window of 2^WIDTH samples.
module stoch_ones_counter #(
   parameter int WIDTH = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           clr,
   input  logic           en,
   input  logic           bit_in,
   output logic [WIDTH:0] ones_next,
   output logic           win_end
);

   localparam logic [WIDTH:0] LAST = {1'b0, {WIDTH{1'b1}}};

   logic [WIDTH:0] ones;
   logic [WIDTH:0] samples;
   logic [WIDTH:0] base_ones;
   logic [WIDTH:0] base_samples;

   // A clear in the same cycle as a sample makes it sample 1.
   assign base_ones    = clr ? '0 : ones;
   assign base_samples = clr ? '0 : samples;
   assign win_end      = en & ~clr & (samples == LAST);
   assign ones_next    = base_ones + {{WIDTH{1'b0}}, en & bit_in};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ones    <= '0;
         samples <= '0;
      end else if (win_end) begin
         ones    <= '0;
         samples <= '0;
      end else if (clr | en) begin
         ones    <= ones_next;
         samples <= base_samples + {{WIDTH{1'b0}}, en};
      end
   end

endmodule

// File: rtl/stoch_to_bin.sv
// Decodes a stochastic bitstream into a WIDTH-bit binary value
// by counting ones over a 2^WIDTH-sample window.
module stoch_to_bin
   import stoch_to_bin_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int CONTINUOUS = 0,
   parameter int BIPOLAR    = 0
) (
   input logic           TRIG,
   input logic           RESET,
   stoch_to_bin_if.slave bus
);

   localparam int WB = WIDTH + 2;
   localparam logic signed [WIDTH+1:0] BOFF = WB'(bip_offset(WIDTH));
   localparam logic signed [WIDTH+1:0] BMAX = WB'(bip_max(WIDTH));
   localparam logic signed [WIDTH+1:0] BMIN = WB'(bip_min(WIDTH));

   logic [1:0]        state;
   logic [WIDTH-1:0]  value_q;
   logic              valid_q;
   logic              ovr_q;
   logic              accum;
   logic              clr;
   logic              win_end;
   logic [WIDTH:0]    ones_next;
   logic [WIDTH-1:0]  fmt;
   logic signed [WIDTH+1:0] diff;

   assign accum = (state == S_ACCUM);
   // START is held off in DONE until the result is taken.
   assign clr   = bus.START & ((state != S_DONE) | bus.OUT_ACK);

   stoch_ones_counter #(
      .WIDTH (WIDTH)
   ) u_cnt (
      .clk       (TRIG),
      .rst       (RESET),
      .clr       (clr),
      .en        (accum & bus.EN),
      .bit_in    (bus.BIT_IN),
      .ones_next (ones_next),
      .win_end   (win_end)
   );

   always_comb begin
      diff = $signed({1'b0, ones_next}) - BOFF;
      fmt  = '0;
      if (BIPOLAR != 0) begin
         if (diff > BMAX)
            fmt = BMAX[WIDTH-1:0];
         else if (diff < BMIN)
            fmt = BMIN[WIDTH-1:0];
         else
            fmt = diff[WIDTH-1:0];
      end else begin
         fmt = ones_next[WIDTH] ? '1 : ones_next[WIDTH-1:0];
      end
   end

   always_ff @(posedge TRIG or posedge RESET) begin
      if (RESET) begin
         state   <= S_IDLE;
         value_q <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (bus.START)
                  state <= S_ACCUM;
            end
            S_ACCUM: begin
               if (win_end) begin
                  value_q <= fmt;
                  valid_q <= 1'b1;
                  if (valid_q & ~bus.OUT_ACK)
                     ovr_q <= 1'b1;
                  if (CONTINUOUS == 0)
                     state <= S_DONE;
               end else if (bus.OUT_ACK) begin
                  valid_q <= 1'b0;
               end
            end
            S_DONE: begin
               if (bus.OUT_ACK) begin
                  valid_q <= 1'b0;
                  state   <= bus.START ? S_ACCUM : S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.VALUE     = value_q;
   assign bus.OUT_VALID = valid_q;
   assign bus.BUSY      = accum;
   assign bus.OVERRUN   = ovr_q;

endmodule

// File: tb/tb_stoch_to_bin.sv
// Bench for stoch_to_bin: unipolar, bipolar and continuous
// WIDTH=4 instances, scoreboarded window results plus corner cases.
module tb_stoch_to_bin;

   logic trig  = 1'b0;
   logic reset = 1'b0;
   logic s = 0, e = 0, b = 0, a = 0;
   logic sc = 0, ec = 0, bc = 0, ac = 0;
   int   checks = 0;
   int   errors = 0;
   logic [3:0] qu[$];
   logic [3:0] qb[$];
   logic pvu = 1'b0;
   logic pvb = 1'b0;

   typedef struct {
      logic [15:0] pat;
      bit          gap;
      logic [3:0]  eu;
      logic [3:0]  eb;
   } vec_t;

   vec_t vt[6];

   stoch_to_bin_if #(.WIDTH(4)) if_u ();
   stoch_to_bin_if #(.WIDTH(4)) if_b ();
   stoch_to_bin_if #(.WIDTH(4)) if_c ();

   assign if_u.START = s;  assign if_u.EN = e;
   assign if_u.BIT_IN = b; assign if_u.OUT_ACK = a;
   assign if_b.START = s;  assign if_b.EN = e;
   assign if_b.BIT_IN = b; assign if_b.OUT_ACK = a;
   assign if_c.START = sc;  assign if_c.EN = ec;
   assign if_c.BIT_IN = bc; assign if_c.OUT_ACK = ac;

   stoch_to_bin #(.WIDTH(4), .CONTINUOUS(0), .BIPOLAR(0)) dut_u (
      .TRIG (trig), .RESET (reset), .bus (if_u.slave)
   );
   stoch_to_bin #(.WIDTH(4), .CONTINUOUS(0), .BIPOLAR(1)) dut_b (
      .TRIG (trig), .RESET (reset), .bus (if_b.slave)
   );
   stoch_to_bin #(.WIDTH(4), .CONTINUOUS(1), .BIPOLAR(0)) dut_c (
      .TRIG (trig), .RESET (reset), .bus (if_c.slave)
   );

   always #5 trig = ~trig;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Scoreboard: a rising OUT_VALID pops the expected result.
   always @(negedge trig) begin
      if (!reset) begin
         if (if_u.OUT_VALID && !pvu) begin
            if (qu.size() == 0) chk("sb_u_unexpected", qu.size(), 1);
            else chk("sb_u_value", if_u.VALUE, qu.pop_front());
         end
         if (if_b.OUT_VALID && !pvb) begin
            if (qb.size() == 0) chk("sb_b_unexpected", qb.size(), 1);
            else chk("sb_b_value", if_b.VALUE, qb.pop_front());
         end
      end
      pvu <= if_u.OUT_VALID;
      pvb <= if_b.OUT_VALID;
   end

   // mode 0: separate START cycle; 1: no START; 2: START with sample 1
   task automatic run_win(input logic [15:0] pat, input bit gap,
                          input int mode, input bit do_ack,
                          input logic [3:0] eu, input logic [3:0] eb,
                          input string nm);
      qu.push_back(eu);
      qb.push_back(eb);
      if (mode == 0) begin
         @(negedge trig); s = 1; e = 0; a = 0;
      end
      for (int i = 0; i < 16; i++) begin
         if (gap) begin
            @(negedge trig); s = 0; e = 0; b = 1'($urandom);
         end
         @(negedge trig);
         if (i == 15) begin
            chk({nm, "_pre_valid"}, if_u.OUT_VALID, 0);
            chk({nm, "_pre_busy"}, if_u.BUSY, 1);
         end
         s = (mode == 2 && i == 0);
         e = 1;
         b = pat[i];
      end
      @(negedge trig); s = 0; e = 0;
      chk({nm, "_valid_u"}, if_u.OUT_VALID, 1);
      chk({nm, "_busy_u"}, if_u.BUSY, 0);
      chk({nm, "_valid_b"}, if_b.OUT_VALID, 1);
      if (do_ack) begin
         a = 1;
         @(negedge trig); a = 0;
         chk({nm, "_ack_u"}, if_u.OUT_VALID, 0);
         chk({nm, "_ack_b"}, if_b.OUT_VALID, 0);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] cp;

      vt[0] = '{16'hEDB5, 1'b0, 4'd11, 4'd3};
      vt[1] = '{16'hFFFF, 1'b0, 4'd15, 4'd7};
      vt[2] = '{16'h0000, 1'b0, 4'd0,  4'h8};
      vt[3] = '{16'hA5A5, 1'b1, 4'd8,  4'd0};
      vt[4] = '{16'h0001, 1'b0, 4'd1,  4'h9};
      vt[5] = '{16'h3F0F, 1'b1, 4'd10, 4'd2};

      #1 reset = 1;
      #1;
      chk("rst_u_value", if_u.VALUE, 0);
      chk("rst_u_valid", if_u.OUT_VALID, 0);
      chk("rst_u_busy", if_u.BUSY, 0);
      chk("rst_u_ovr", if_u.OVERRUN, 0);
      chk("rst_b_value", if_b.VALUE, 0);
      chk("rst_c_valid", if_c.OUT_VALID, 0);
      chk("rst_c_busy", if_c.BUSY, 0);
      chk("rst_c_ovr", if_c.OVERRUN, 0);

      @(negedge trig); reset = 0;
      @(negedge trig); a = 1;
      @(negedge trig); a = 0;
      chk("idle_ack_valid", if_u.OUT_VALID, 0);
      chk("idle_ack_busy", if_u.BUSY, 0);

      for (int k = 0; k < 6; k++)
         run_win(vt[k].pat, vt[k].gap, 0, 1, vt[k].eu, vt[k].eb,
                 $sformatf("vec%0d", k));

      // START while DONE is ignored; START with OUT_ACK restarts
      run_win(16'h7777, 0, 0, 0, 4'd12, 4'd4, "done");
      s = 1;
      @(negedge trig); s = 0;
      chk("done_start_valid", if_u.OUT_VALID, 1);
      chk("done_start_busy", if_u.BUSY, 0);
      chk("done_start_value", if_u.VALUE, 12);
      s = 1; a = 1;
      @(negedge trig); s = 0; a = 0;
      chk("done_startack_valid", if_u.OUT_VALID, 0);
      chk("done_startack_busy", if_u.BUSY, 1);
      run_win(16'h8000, 0, 1, 1, 4'd1, 4'h9, "after_done");

      // abort after 7 samples; the START-cycle sample counts
      @(negedge trig); s = 1; e = 0;
      repeat (7) begin
         @(negedge trig); s = 0; e = 1; b = 1;
      end
      run_win(16'h1111, 0, 2, 1, 4'd4, 4'hC, "restart");

      // continuous, OUT_ACK low across two back-to-back windows
      cp = {16'h01FF, 16'h1113};
      @(negedge trig); sc = 1; ec = 0; ac = 0;
      for (int i = 0; i < 32; i++) begin
         @(negedge trig);
         if (i == 15) chk("cont_w1_pre_valid", if_c.OUT_VALID, 0);
         if (i == 16) begin
            chk("cont_w1_valid", if_c.OUT_VALID, 1);
            chk("cont_w1_value", if_c.VALUE, 5);
            chk("cont_w1_busy", if_c.BUSY, 1);
            chk("cont_w1_ovr", if_c.OVERRUN, 0);
         end
         sc = 0; ec = 1; bc = cp[i];
      end
      @(negedge trig); ec = 0;
      chk("cont_w2_value", if_c.VALUE, 9);
      chk("cont_w2_valid", if_c.OUT_VALID, 1);
      chk("cont_w2_ovr", if_c.OVERRUN, 1);
      chk("cont_w2_busy", if_c.BUSY, 1);
      ac = 1;
      @(negedge trig); ac = 0;
      chk("cont_ack_valid", if_c.OUT_VALID, 0);
      chk("cont_ack_ovr", if_c.OVERRUN, 1);

      // asynchronous reset mid-window
      @(negedge trig); s = 1; e = 0; ec = 1; bc = 1;
      repeat (5) begin
         @(negedge trig); s = 0; e = 1; b = 1;
      end
      @(posedge trig);
      #3 reset = 1;
      #1;
      chk("arst_u_busy", if_u.BUSY, 0);
      chk("arst_u_value", if_u.VALUE, 0);
      chk("arst_u_valid", if_u.OUT_VALID, 0);
      chk("arst_b_value", if_b.VALUE, 0);
      chk("arst_c_busy", if_c.BUSY, 0);
      chk("arst_c_value", if_c.VALUE, 0);
      chk("arst_c_ovr", if_c.OVERRUN, 0);
      @(negedge trig); reset = 0; e = 1; b = 1; ec = 1; bc = 1;
      repeat (4) @(negedge trig);
      chk("post_rst_u_busy", if_u.BUSY, 0);
      chk("post_rst_c_busy", if_c.BUSY, 0);
      chk("post_rst_c_valid", if_c.OUT_VALID, 0);
      e = 0; ec = 0;
      run_win(16'hEDB5, 1, 0, 1, 4'd11, 4'd3, "post_rst");

      repeat (2) @(negedge trig);
      chk("sb_drain_u", qu.size(), 0);
      chk("sb_drain_b", qb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/stoch_to_bin.md
STOCH_TO_BIN -- requirements
Module: stoch_to_bin

Interface
REQ-001 Parameter WIDTH, default 8: binary result width; window length is 2^WIDTH samples.
REQ-002 Parameter CONTINUOUS, default 0: 1 = auto-restart a new window after each result.
REQ-003 Parameter BIPOLAR, default 0: 1 = two's-complement bipolar output; 0 = unipolar unsigned output.
REQ-004 TRIG  input  1  clock, rising-edge active.
REQ-005 RESET  input  1  reset RESET, asynchronous, active-high.
REQ-006 START  input  1  single-cycle request to begin a window.
REQ-007 EN  input  1  qualifies BIT_IN as a valid stochastic sample this cycle.
REQ-008 BIT_IN  input  1  stochastic bitstream sample, as produced by the LFSR-comparator generator.
REQ-009 OUT_ACK  input  1  consumer accepts VALUE.
REQ-010 VALUE  output  WIDTH  decoded binary result, held stable while OUT_VALID=1.
REQ-011 OUT_VALID  output  1  VALUE is valid and unconsumed.
REQ-012 BUSY  output  1  window accumulation in progress.
REQ-013 OVERRUN  output  1  sticky flag: a completed result was discarded unacknowledged.

Function
REQ-014 FSM states: IDLE, ACCUM, DONE.
REQ-015 IDLE: BUSY=0; START=1 -> ACCUM next cycle, with ones-count and sample-count cleared.
REQ-016 ACCUM: BUSY=1; each cycle with EN=1 increments sample-count, and increments ones-count when BIT_IN=1; cycles with EN=0 change nothing.
REQ-017 Ones-count and sample-count are WIDTH+1 bits wide; the window ends on the cycle the 2^WIDTH-th qualified sample is taken, and that sample is included.
REQ-018 Window end: VALUE and OUT_VALID update on the next rising edge; latency from the last qualified sample to OUT_VALID=1 is exactly 1 cycle.
REQ-019 Unipolar: VALUE = ones-count, saturated to 2^WIDTH-1 when ones-count = 2^WIDTH.
REQ-020 Bipolar: VALUE = ones-count - 2^(WIDTH-1), clamped to [-(2^(WIDTH-1)), 2^(WIDTH-1)-1], two's complement.
REQ-021 CONTINUOUS=0: window end -> DONE; BUSY=0; OUT_VALID held until OUT_ACK=1, then OUT_VALID=0 next cycle -> IDLE.
REQ-022 CONTINUOUS=1: window end -> ACCUM with counts cleared; no sample is lost, and the first qualified sample in the cycle after window end belongs to the new window.
REQ-023 CONTINUOUS=1: if a new result completes while OUT_VALID=1 and OUT_ACK=0, VALUE is overwritten, OUT_VALID stays 1, and OVERRUN is set.
REQ-024 OUT_ACK with OUT_VALID=0 is ignored.
REQ-025 START during ACCUM: abort the current window; counts clear; a sample qualified in that same cycle counts as sample 1 of the new window.
REQ-026 START in DONE: ignored until the result is acknowledged; START and OUT_ACK in the same cycle -> ACCUM directly, and OUT_VALID=0.
REQ-027 OVERRUN clears only on RESET.
REQ-028 VALUE is unchanged outside the result-update edge.

Reset
REQ-029 RESET=1: state=IDLE, counts=0, VALUE=0, OUT_VALID=0, BUSY=0, OVERRUN=0, immediately and without waiting for TRIG.
REQ-030 RESET asserted mid-window discards partial counts; after deassertion the block waits for START, including when CONTINUOUS=1.

Structure
REQ-031 A shared package holds the FSM state enum and the bipolar offset/clamp constants as functions of WIDTH.
REQ-032 One sub-module, stoch_ones_counter, holds the EN-qualified ones-count and sample-count, with a clear input and a window-end output; the FSM, result formatting and handshake stay in stoch_to_bin.

Verification
REQ-033 WIDTH=4, unipolar: START, 16 EN samples with 11 ones -> OUT_VALID=1 one cycle after the 16th sample, VALUE=11, BUSY=0.
REQ-034 WIDTH=4: all 16 samples =1 -> VALUE=15 (saturated); repeat with BIPOLAR=1 -> VALUE=7; all 0 with BIPOLAR=1 -> VALUE=-8 (4'b1000).
REQ-035 EN toggling 50% with 16 qualified samples containing 8 ones -> window spans 32 cycles, VALUE=8; bipolar run gives VALUE=0.
REQ-036 CONTINUOUS=1 with OUT_ACK tied low across two windows (5 ones, then 9 ones) -> VALUE=9, OVERRUN=1, and no samples are dropped at the window boundary.
REQ-037 START pulsed after 7 samples -> window restarts; result counts only the 16 samples following START.
REQ-038 RESET asserted asynchronously between edges mid-ACCUM -> all outputs 0 immediately; a later START yields a correct fresh result.
